// File: rtl/fp_mat_pkg.sv
// Shared definitions for the fixed-point matrix pack/unpack blocks.
// Holds the default element format, the streaming FSM states and the index-width helper.
package fp_mat_pkg;

    localparam int FP_DATA_WIDTH = 16;
    localparam int FP_FRAC_BITS  = 8;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // Index counters need at least one bit even for a single row or column.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mat_index_counter.sv
// Nested row/column index counter walking a ROW x COL matrix in row- or column-major order.
// Wraps both indices back to (0,0) after the final element, so no explicit clear is needed between matrices.
module mat_index_counter
    import fp_mat_pkg::*;
#(
    parameter  int ROW       = 4,
    parameter  int COL       = 2,
    parameter  int COL_MAJOR = 0,
    localparam int RW        = idx_width(ROW),
    localparam int CW        = idx_width(COL)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          en,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          last
);

    localparam logic [RW-1:0] ROW_MAX = RW'(ROW - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COL - 1);

    logic [RW-1:0] row_r;
    logic [CW-1:0] col_r;

    // Advance the fast index; carry into the slow index when the fast one wraps.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            row_r <= '0;
            col_r <= '0;
        end else if (en) begin
            if (COL_MAJOR != 0) begin
                if (row_r == ROW_MAX) begin
                    row_r <= '0;
                    col_r <= (col_r == COL_MAX) ? '0 : col_r + CW'(1'b1);
                end else begin
                    row_r <= row_r + RW'(1'b1);
                end
            end else begin
                if (col_r == COL_MAX) begin
                    col_r <= '0;
                    row_r <= (row_r == ROW_MAX) ? '0 : row_r + RW'(1'b1);
                end else begin
                    col_r <= col_r + CW'(1'b1);
                end
            end
        end
    end

    assign row  = row_r;
    assign col  = col_r;
    assign last = (row_r == ROW_MAX) && (col_r == COL_MAX);

endmodule

// File: rtl/fp_mat_unpacker.sv
// Captures a flat packed matrix and streams it out one element per handshake.
// out_data is a mux over the captured bank only; in_mat is never on the output path.
module fp_mat_unpacker
    import fp_mat_pkg::*;
#(
    parameter  int DATA_WIDTH = FP_DATA_WIDTH,
    parameter  int ROW        = 4,
    parameter  int COL        = 2,
    parameter  int COL_MAJOR  = 0,
    localparam int RW         = idx_width(ROW),
    localparam int CW         = idx_width(COL)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH*ROW*COL-1:0] in_mat,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [RW-1:0]                 out_row,
    output logic [CW-1:0]                 out_col,
    output logic                          out_last,
    output logic                          out_valid,
    input  logic                          out_ready
);

    state_t                        state_r;
    logic [DATA_WIDTH*ROW*COL-1:0] mat_r;
    logic                          out_valid_r;
    logic                          in_ready_r;
    logic                          capture_s;
    logic                          advance_s;
    logic                          last_s;
    logic [RW-1:0]                 row_s;
    logic [CW-1:0]                 col_s;
    int unsigned                   elem_s;

    assign capture_s = (state_r == IDLE) && in_valid;
    assign advance_s = (state_r == STREAM) && out_ready;

    mat_index_counter #(
        .ROW       (ROW),
        .COL       (COL),
        .COL_MAJOR (COL_MAJOR)
    ) u_index (
        .clk   (clk),
        .rst   (rst),
        .clear (capture_s),
        .en    (advance_s),
        .row   (row_s),
        .col   (col_s),
        .last  (last_s)
    );

    // Handshake FSM with registered in_ready/out_valid; reset clears the bank so no stale element survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            mat_r       <= '0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        mat_r       <= in_mat;
                        state_r     <= STREAM;
                        out_valid_r <= 1'b1;
                        in_ready_r  <= 1'b0;
                    end
                end
                STREAM: begin
                    if (out_ready && last_s) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    // Flat element position of the current index in the packed bank.
    always_comb begin
        elem_s = 32'(row_s) * 32'(COL) + 32'(col_s);
    end

    assign out_data  = mat_r[elem_s*DATA_WIDTH +: DATA_WIDTH];
    assign out_row   = row_s;
    assign out_col   = col_s;
    assign out_last  = out_valid_r && last_s;
    assign out_valid = out_valid_r;
    assign in_ready  = in_ready_r;

endmodule

// File: tb/tb_fp_mat_unpacker.sv
// Scoreboard bench driving a row-major and a column-major unpacker with identical stimulus.
// A cycle model predicts handshake state and queues the expected beats per ordering.
module tb_fp_mat_unpacker;

    typedef struct packed {
        logic [15:0] d;
        logic [1:0]  r;
        logic        c;
        logic        l;
    } beat_t;

    logic         clk;
    logic         rst;
    logic [127:0] in_mat;
    logic         in_valid;
    logic         out_ready;

    logic         in_ready_rm, out_valid_rm, out_last_rm;
    logic [15:0]  out_data_rm;
    logic [1:0]   out_row_rm;
    logic [0:0]   out_col_rm;
    logic         in_ready_cm, out_valid_cm, out_last_cm;
    logic [15:0]  out_data_cm;
    logic [1:0]   out_row_cm;
    logic [0:0]   out_col_cm;

    int    tests_run = 0;
    int    tests_failed = 0;
    int    accepted = 0;
    logic  busy = 1'b0;
    logic  cleared = 1'b1;
    beat_t q_rm[$];
    beat_t q_cm[$];

    fp_mat_unpacker #(.DATA_WIDTH(16), .ROW(4), .COL(2), .COL_MAJOR(0)) u_rm (
        .clk(clk), .rst(rst), .in_mat(in_mat), .in_valid(in_valid), .in_ready(in_ready_rm),
        .out_data(out_data_rm), .out_row(out_row_rm), .out_col(out_col_rm),
        .out_last(out_last_rm), .out_valid(out_valid_rm), .out_ready(out_ready)
    );

    fp_mat_unpacker #(.DATA_WIDTH(16), .ROW(4), .COL(2), .COL_MAJOR(1)) u_cm (
        .clk(clk), .rst(rst), .in_mat(in_mat), .in_valid(in_valid), .in_ready(in_ready_cm),
        .out_data(out_data_cm), .out_row(out_row_cm), .out_col(out_col_cm),
        .out_last(out_last_cm), .out_valid(out_valid_cm), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_dut(input string nm, input logic ir, input logic ov, input logic [15:0] d,
                             input logic [1:0] r, input logic c, input logic l, input beat_t e);
        check_eq({nm, "_in_ready"}, 32'(ir), 32'(!busy));
        check_eq({nm, "_out_valid"}, 32'(ov), 32'(busy));
        if (busy) begin
            check_eq({nm, "_data"}, 32'(d), 32'(e.d));
            check_eq({nm, "_row"}, 32'(r), 32'(e.r));
            check_eq({nm, "_col"}, 32'(c), 32'(e.c));
            check_eq({nm, "_last"}, 32'(l), 32'(e.l));
        end else begin
            check_eq({nm, "_idle_row"}, 32'(r), 32'd0);
            check_eq({nm, "_idle_col"}, 32'(c), 32'd0);
            check_eq({nm, "_idle_last"}, 32'(l), 32'd0);
            if (cleared) begin
                check_eq({nm, "_cleared_data"}, 32'(d), 32'd0);
            end
        end
    endtask

    task automatic push_matrix(input logic [127:0] m);
        beat_t b;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 2; j++) begin
                b.d = m[16*(i*2+j) +: 16];
                b.r = 2'(i);
                b.c = 1'(j);
                b.l = (i == 3) && (j == 1);
                q_rm.push_back(b);
            end
        end
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < 4; i++) begin
                b.d = m[16*(i*2+j) +: 16];
                b.r = 2'(i);
                b.c = 1'(j);
                b.l = (i == 3) && (j == 1);
                q_cm.push_back(b);
            end
        end
    endtask

    // Compare both DUTs against the model, then predict what the coming posedge does.
    always @(negedge clk) begin
        beat_t e_rm;
        beat_t e_cm;
        e_rm = (q_rm.size() > 0) ? q_rm[0] : '0;
        e_cm = (q_cm.size() > 0) ? q_cm[0] : '0;
        check_dut("rm", in_ready_rm, out_valid_rm, out_data_rm, out_row_rm, out_col_rm, out_last_rm, e_rm);
        check_dut("cm", in_ready_cm, out_valid_cm, out_data_cm, out_row_cm, out_col_cm, out_last_cm, e_cm);
        if (rst) begin
            busy = 1'b0;
            cleared = 1'b1;
            q_rm.delete();
            q_cm.delete();
        end else if (!busy && in_valid) begin
            push_matrix(in_mat);
            busy = 1'b1;
            cleared = 1'b0;
        end else if (busy && out_ready) begin
            void'(q_rm.pop_front());
            void'(q_cm.pop_front());
            accepted++;
            if (q_rm.size() == 0) begin
                busy = 1'b0;
            end
        end
    end

    function automatic logic [127:0] mk(input logic [15:0] base, input logic [15:0] step);
        logic [127:0] m;
        for (int k = 0; k < 8; k++) begin
            m[16*k +: 16] = base + step * 16'(k);
        end
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] m);
        in_mat   = m;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        int base;
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_mat    = '1;
        out_ready = 1'b1;
        repeat (3) tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (3) tick();

        // Full-throughput stream of 1.0 .. 8.0.
        send(mk(16'h0100, 16'h0100));
        repeat (10) tick();

        // Backpressure: toggling ready, then a long stall mid-matrix.
        base = accepted;
        send(mk(16'h1234, 16'h0111));
        for (int i = 0; i < 6; i++) begin
            out_ready = ~out_ready;
            tick();
        end
        out_ready = 1'b0;
        repeat (5) tick();
        out_ready = 1'b1;
        repeat (10) tick();
        check_eq("bp_accepts", 32'(accepted - base), 32'd8);

        // Reset after the third accepted element, then a fresh 0.5 matrix.
        base = accepted;
        send(mk(16'h0A00, 16'h0001));
        for (int i = 0; i < 20 && accepted < base + 3; i++) tick();
        check_eq("mid_rst_reached", 32'(accepted - base), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        send(mk(16'h0080, 16'h0000));
        repeat (10) tick();

        // Back-to-back with in_valid held and in_mat changing mid-stream.
        base = accepted;
        in_mat   = mk(16'h2000, 16'h0010);
        in_valid = 1'b1;
        tick();
        in_mat = mk(16'h3000, 16'h0020);
        repeat (10) tick();
        in_mat   = mk(16'h4000, 16'h0030);
        in_valid = 1'b0;
        repeat (12) tick();
        check_eq("b2b_accepts", 32'(accepted - base), 32'd16);
        check_eq("queue_empty", 32'(q_rm.size() + q_cm.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
